// File: rtl/uart_baud_ctrl.sv
// UART oversampling tick generator with deferred runtime divisor update.
// Optional DRAIN timeout: define UART_BAUD_CTRL_TIMEOUT_EN.
module uart_baud_ctrl #(
  parameter int unsigned CLK_FREQ      = 100000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  input  logic             i_tx_busy,
  input  logic             i_rx_busy,
  output logic             o_tick,
  output logic [DIV_W-1:0] o_cur_div,
  output logic             o_cfg_err
);

  localparam int unsigned RST_DIV_I =
    CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [DIV_W-1:0] RST_DIV = RST_DIV_I[DIV_W-1:0];
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    LOAD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             xfer, bad, quiet;

`ifdef UART_BAUD_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);
  logic [TO_W-1:0] dcnt_q, dcnt_d;
`endif

  assign xfer  = i_cfg_valid & ready_q;
  assign bad   = i_cfg_div < TWO;
  assign quiet = ~i_tx_busy & ~i_rx_busy;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    err_d   = xfer & bad;
    count_d = '0;
    tick_d  = 1'b0;
`ifdef UART_BAUD_CTRL_TIMEOUT_EN
    dcnt_d  = (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;
`endif
    // Counter wraps at the divisor in effect; LOAD restarts phase.
    if (state_q == LOAD) begin
      div_d = pend_q;
    end else if (i_enable) begin
      tick_d  = count_q >= div_q - ONE;
      count_d = tick_d ? '0 : count_q + ONE;
    end
    unique case (state_q)
      IDLE: begin
        if (xfer && !bad) begin
          pend_d  = i_cfg_div;
          state_d = LOAD;
        end else if (i_enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer && !bad) begin
          pend_d  = i_cfg_div;
          state_d = DRAIN;
        end else if (!i_enable) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (quiet || !i_enable) begin
          state_d = LOAD;
`ifdef UART_BAUD_CTRL_TIMEOUT_EN
        end else if (dcnt_q == TO_LAST) begin
          state_d = RUN;
          pend_d  = '0;
          err_d   = 1'b1;
`endif
        end
      end
      LOAD: begin
        state_d = i_enable ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= RST_DIV;
      pend_q  <= '0;
      tick_q  <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
`ifdef UART_BAUD_CTRL_TIMEOUT_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef UART_BAUD_CTRL_TIMEOUT_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign o_tick      = tick_q;
  assign o_cur_div   = div_q;
  assign o_cfg_ready = ready_q;
  assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed scoreboard bench for uart_baud_ctrl.
// Expectations queued at stimulus time, compared at the negedge.
module tb_uart_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        tx_busy;
  logic        rx_busy;
  logic        tick;
  logic [15:0] cur_div;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  uart_baud_ctrl #(
    .DRAIN_TIMEOUT(200)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (en),
    .i_cfg_valid(cfg_valid),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(cfg_ready),
    .i_tx_busy  (tx_busy),
    .i_rx_busy  (rx_busy),
    .o_tick     (tick),
    .o_cur_div  (cur_div),
    .o_cfg_err  (cfg_err)
  );

  task automatic ex(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  // Cycles (negedges) until the next tick; -1 if none within the bound.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 300);
    if (tick !== 1'b1) n = -1;
  endtask

  task automatic tick_gap(input string t, input int v);
    int n;
    ex(t, 32'(v));
    wait_tick(n);
    got(32'(n));
  endtask

  initial begin
    int n;
    int cnt;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    tx_busy   = 1'b0;
    rx_busy   = 1'b0;
    repeat (3) @(negedge clk);
    ex("rst_div", 54);
    ex("rst_tick", 0);
    ex("rst_ready", 1);
    ex("rst_err", 0);
    got(32'(cur_div));
    got(32'(tick));
    got(32'(cfg_ready));
    got(32'(cfg_err));

    rst_n = 1'b1;
    en    = 1'b1;
    tick_gap("first_tick", 54);
    tick_gap("period54", 54);
    ex("div54", 54);
    got(32'(cur_div));

    en  = 1'b0;
    cnt = 0;
    ex("ticks_while_off", 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick === 1'b1) cnt++;
    end
    got(32'(cnt));
    en = 1'b1;
    tick_gap("reenable_tick", 54);

    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    ex("reject_err", 1);
    @(negedge clk);
    got(32'(cfg_err));
    cfg_valid = 1'b0;
    ex("reject_err_one", 0);
    ex("reject_div", 54);
    ex("reject_ready", 1);
    @(negedge clk);
    got(32'(cfg_err));
    got(32'(cur_div));
    got(32'(cfg_ready));
    tick_gap("reject_phase", 52);

    cfg_valid = 1'b1;
    cfg_div   = 16'd27;
    tx_busy   = 1'b1;
    ex("drain_ready", 0);
    @(negedge clk);
    got(32'(cfg_ready));
    cfg_valid = 1'b0;
    tick_gap("drain_phase", 53);
    for (int i = 0; i < 8; i++) tick_gap("drain_period", 54);
    ex("drain_ready_hold", 0);
    ex("drain_div_hold", 54);
    got(32'(cfg_ready));
    got(32'(cur_div));
    tx_busy = 1'b0;
    ex("load_div_old", 54);
    ex("load_ready", 0);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(cfg_ready));
    ex("new_div", 27);
    ex("new_ready", 1);
    ex("new_tick0", 0);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(cfg_ready));
    got(32'(tick));
    tick_gap("new_first", 27);
    tick_gap("new_period", 27);

    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    tx_busy   = 1'b1;
    ex("rd_ready", 0);
    @(negedge clk);
    got(32'(cfg_ready));
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    ex("rd_div", 54);
    ex("rd_ready_rst", 1);
    ex("rd_tick", 0);
    ex("rd_err", 0);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(cfg_ready));
    got(32'(tick));
    got(32'(cfg_err));
    rst_n   = 1'b1;
    tx_busy = 1'b0;
    tick_gap("rd_first", 54);
    tick_gap("rd_period", 54);

    en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 16'd2;
    ex("idle_ready", 0);
    ex("idle_div_old", 54);
    @(negedge clk);
    got(32'(cfg_ready));
    got(32'(cur_div));
    cfg_valid = 1'b0;
    ex("idle_div_new", 2);
    ex("idle_ready_back", 1);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(cfg_ready));
    en = 1'b1;
    tick_gap("div2_first", 2);
    tick_gap("div2_period", 2);

    cfg_valid = 1'b1;
    cfg_div   = 16'd40;
    rx_busy   = 1'b1;
    ex("enoff_ready", 0);
    @(negedge clk);
    got(32'(cfg_ready));
    cfg_valid = 1'b0;
    en        = 1'b0;
    ex("enoff_div_old", 2);
    ex("enoff_tick", 0);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(tick));
    ex("enoff_div_new", 40);
    ex("enoff_ready_back", 1);
    @(negedge clk);
    got(32'(cur_div));
    got(32'(cfg_ready));

    en = 1'b1;
    tick_gap("div40_first", 40);
    cfg_valid = 1'b1;
    cfg_div   = 16'd100;
    ex("to_ready", 0);
    @(negedge clk);
    got(32'(cfg_ready));
    cfg_valid = 1'b0;
`ifdef UART_BAUD_CTRL_TIMEOUT_EN
    ex("to_err_cycle", 201);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (cfg_err !== 1'b1 && n < 400);
    if (cfg_err !== 1'b1) n = -1;
    got(32'(n));
    ex("to_div", 40);
    ex("to_ready_back", 1);
    got(32'(cur_div));
    got(32'(cfg_ready));
    rx_busy = 1'b0;
`else
    cnt = 0;
    ex("stuck_no_err", 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cfg_err === 1'b1) cnt++;
    end
    got(32'(cnt));
    ex("stuck_ready", 0);
    ex("stuck_div", 40);
    got(32'(cfg_ready));
    got(32'(cur_div));
    rx_busy = 1'b0;
    repeat (2) @(negedge clk);
    ex("stuck_release_div", 100);
    got(32'(cur_div));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
